// File: rtl/param_cascade_counter_if.sv
// Bus bundle for param_cascade_counter: mode/enable/data in, count/carry/flag out.
// The master side drives control and data; the counter is the slave.
interface param_cascade_counter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       s;
  logic             enpN;
  logic             entN;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] modulo;
  logic             clrWrap;
  logic [WIDTH-1:0] q;
  logic             rcoN;
  logic             wrapped;

  modport master (
    output s, enpN, entN, d, modulo, clrWrap,
    input  q, rcoN, wrapped
  );

  modport slave (
    input  s, enpN, entN, d, modulo, clrWrap,
    output q, rcoN, wrapped
  );
endinterface

// File: rtl/param_cascade_counter.sv
// Cascadable up/down/load/clear counter with sticky wrap flag.
// Define PARAM_COUNTER_MODULO_EN to take the terminal value from the modulo input.
module param_cascade_counter #(
  parameter int WIDTH   = 8,
  parameter int ONESHOT = 0
) (
  input logic                          clk,
  input logic                          asyncResetN,
  param_cascade_counter_if.slave       bus
);
  localparam logic [1:0] S_CLR  = 2'b00;
  localparam logic [1:0] S_DOWN = 2'b01;
  localparam logic [1:0] S_LOAD = 2'b10;
  localparam logic [1:0] S_UP   = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH-1:0] top_val;
  logic             en;
  logic             up_term;
  logic             dn_term;
  logic             term_hit;

`ifdef PARAM_COUNTER_MODULO_EN
  assign top_val = bus.modulo;
`else
  logic unused_modulo;
  assign top_val       = '1;
  assign unused_modulo = ^bus.modulo;
`endif

  assign en      = ~bus.enpN & ~bus.entN;
  assign up_term = (q_q >= top_val);
  assign dn_term = (q_q == '0);

  // Next count and terminal-branch detection from mode and enables.
  always_comb begin
    q_d      = q_q;
    term_hit = 1'b0;
    unique case (bus.s)
      S_LOAD: q_d = bus.d;
      S_CLR: begin
        if (en) q_d = '0;
      end
      S_UP: begin
        if (en) begin
          if (up_term) begin
            term_hit = 1'b1;
            q_d      = (ONESHOT != 0) ? q_q : '0;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
      end
      S_DOWN: begin
        if (en) begin
          if (dn_term) begin
            term_hit = 1'b1;
            q_d      = (ONESHOT != 0) ? '0 : top_val;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
      end
    endcase
  end

  // Sticky flag: a terminal hit beats a same-cycle clear.
  always_comb begin
    wrapped_d = wrapped_q;
    if (bus.clrWrap) wrapped_d = 1'b0;
    if (term_hit)    wrapped_d = 1'b1;
  end

  // Count and flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      q_q       <= '0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.wrapped = wrapped_q;
  assign bus.rcoN    = ~(~bus.entN &
                         (((bus.s == S_UP) & up_term) |
                          ((bus.s == S_DOWN) & dn_term)));
endmodule

// File: tb/tb_param_cascade_counter.sv
// Bench for param_cascade_counter: vector table, corner sequences,
// cascade pair, and random stimulus against a reference model.
module tb_param_cascade_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  param_cascade_counter_if #(.WIDTH(8)) i0 ();
  param_cascade_counter_if #(.WIDTH(8)) i1 ();
  param_cascade_counter_if #(.WIDTH(4)) ilo ();
  param_cascade_counter_if #(.WIDTH(4)) ihi ();

  param_cascade_counter #(.WIDTH(8), .ONESHOT(0)) u0 (
    .clk(clk), .asyncResetN(rst_n), .bus(i0.slave));
  param_cascade_counter #(.WIDTH(8), .ONESHOT(1)) u1 (
    .clk(clk), .asyncResetN(rst_n), .bus(i1.slave));
  param_cascade_counter #(.WIDTH(4), .ONESHOT(0)) ulo (
    .clk(clk), .asyncResetN(rst_n), .bus(ilo.slave));
  param_cascade_counter #(.WIDTH(4), .ONESHOT(0)) uhi (
    .clk(clk), .asyncResetN(rst_n), .bus(ihi.slave));

  assign ihi.entN = ilo.rcoN;

  typedef struct {
    logic [1:0] s;
    bit         enpN;
    bit         entN;
    logic [7:0] d;
    bit         clr;
    bit         rco;
    logic [7:0] q;
    bit         w;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] top_of(logic [7:0] m);
`ifdef PARAM_COUNTER_MODULO_EN
    return m;
`else
    return 8'hFF;
`endif
  endfunction

  // Behavioural next state: returns {wrapped, q}.
  function automatic logic [8:0] ref_next(bit os, logic [7:0] q, bit w,
      logic [1:0] s, bit enpN, bit entN, logic [7:0] d, logic [7:0] top,
      bit clr);
    int nq = int'(q);
    bit hit = 0;
    bit en = !enpN && !entN;
    if (s == 2'b10) nq = int'(d);
    else if (en) begin
      case (s)
        2'b00: nq = 0;
        2'b11: if (q >= top) begin
          hit = 1;
          nq = os ? int'(q) : 0;
        end else nq = (int'(q) + 1) % 256;
        2'b01: if (q == 0) begin
          hit = 1;
          nq = os ? 0 : int'(top);
        end else nq = int'(q) - 1;
        default: ;
      endcase
    end
    return {hit ? 1'b1 : (clr ? 1'b0 : w), 8'(nq)};
  endfunction

  function automatic bit ref_rco(logic [7:0] q, logic [1:0] s, bit entN,
      logic [7:0] top);
    return !(!entN && ((s == 2'b11 && q >= top) || (s == 2'b01 && q == 0)));
  endfunction

  task automatic drive0(logic [1:0] s, bit enpN, bit entN, logic [7:0] d,
      logic [7:0] m, bit clr);
    i0.s = s; i0.enpN = enpN; i0.entN = entN;
    i0.d = d; i0.modulo = m; i0.clrWrap = clr;
  endtask

  task automatic drive1(logic [1:0] s, bit enpN, bit entN, logic [7:0] d,
      logic [7:0] m, bit clr);
    i1.s = s; i1.enpN = enpN; i1.entN = entN;
    i1.d = d; i1.modulo = m; i1.clrWrap = clr;
  endtask

  task automatic drive_casc(logic [1:0] s, bit enpN, bit entN,
      logic [7:0] d);
    ilo.s = s; ihi.s = s;
    ilo.enpN = enpN; ihi.enpN = enpN;
    ilo.entN = entN;
    ilo.d = d[3:0]; ihi.d = d[7:4];
    ilo.modulo = 4'hF; ihi.modulo = 4'hF;
    ilo.clrWrap = 1'b0; ihi.clrWrap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mq0, mq1, mod, top, cnt, eq;
    bit mw0, mw1;
    logic [8:0] nx;
    logic [1:0] rs;
    bit rp, rt, rc;
    logic [7:0] rd;

    tbl[0]  = '{2'b10, 1, 1, 8'hFE, 0, 1, 8'hFE, 0};
    tbl[1]  = '{2'b11, 0, 0, 8'h00, 0, 1, 8'hFF, 0};
    tbl[2]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 1};
    tbl[3]  = '{2'b11, 0, 0, 8'h00, 1, 1, 8'h01, 0};
    tbl[4]  = '{2'b01, 0, 0, 8'h00, 0, 1, 8'h00, 0};
    tbl[5]  = '{2'b01, 0, 0, 8'h00, 1, 0, 8'hFF, 1};
    tbl[6]  = '{2'b01, 1, 0, 8'h00, 0, 1, 8'hFF, 1};
    tbl[7]  = '{2'b11, 1, 0, 8'h00, 0, 0, 8'hFF, 1};
    tbl[8]  = '{2'b11, 0, 1, 8'h00, 0, 1, 8'hFF, 1};
    tbl[9]  = '{2'b00, 1, 0, 8'h00, 0, 1, 8'hFF, 1};
    tbl[10] = '{2'b00, 0, 0, 8'h00, 0, 1, 8'h00, 1};
    tbl[11] = '{2'b10, 1, 1, 8'h5A, 0, 1, 8'h5A, 1};
    tbl[12] = '{2'b11, 1, 0, 8'h00, 0, 1, 8'h5A, 1};
    tbl[13] = '{2'b11, 1, 1, 8'h00, 1, 1, 8'h5A, 0};

    drive0(2'b00, 1, 1, 8'h00, 8'hFF, 0);
    drive1(2'b00, 1, 1, 8'h00, 8'hFF, 0);
    drive_casc(2'b00, 1, 1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_q", i0.q, 8'h00);
    chk("reset_wrapped", i0.wrapped, 0);
    chk("reset_rcoN", i0.rcoN, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive0(tbl[i].s, tbl[i].enpN, tbl[i].entN, tbl[i].d, 8'hFF,
             tbl[i].clr);
      #1;
      chk($sformatf("tbl%0d_rcoN", i), i0.rcoN, tbl[i].rco);
      tick();
      chk($sformatf("tbl%0d_q", i), i0.q, tbl[i].q);
      chk($sformatf("tbl%0d_wrapped", i), i0.wrapped, tbl[i].w);
    end

    // Up-count under a programmed modulo (ignored without the macro).
    @(negedge clk);
    drive0(2'b10, 1, 1, 8'h00, 8'd9, 0);
    tick();
    top = top_of(8'd9);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive0(2'b11, 0, 0, 8'h00, 8'd9, 0);
      #1;
      chk($sformatf("mod_rcoN%0d", k), i0.rcoN, (k == int'(top)) ? 0 : 1);
      tick();
      eq = 8'((k + 1) % (int'(top) + 1));
      chk($sformatf("mod_q%0d", k), i0.q, eq);
    end

    // One-shot down at zero saturates.
    @(negedge clk);
    drive1(2'b10, 1, 1, 8'h00, 8'hFF, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive1(2'b01, 0, 0, 8'h00, 8'hFF, 0);
      #1;
      chk($sformatf("os_rcoN%0d", k), i1.rcoN, 0);
      tick();
      chk($sformatf("os_q%0d", k), i1.q, 8'h00);
      chk($sformatf("os_w%0d", k), i1.wrapped, 1);
    end
    @(negedge clk);
    drive1(2'b10, 1, 1, 8'hFF, 8'hFF, 1);
    tick();
    @(negedge clk);
    drive1(2'b11, 0, 0, 8'h00, 8'hFF, 0);
    tick();
    chk("os_up_hold_q", i1.q, 8'hFF);
    chk("os_up_hold_w", i1.wrapped, 1);

    // Two 4-bit stages cascaded.
    @(negedge clk);
    drive_casc(2'b10, 1, 1, 8'h0F);
    tick();
    @(negedge clk);
    drive_casc(2'b11, 0, 0, 8'h00);
    #1;
    chk("casc_lo_rcoN_F", ilo.rcoN, 0);
    tick();
    chk("casc_q_10", {ihi.q, ilo.q}, 8'h10);
    chk("casc_lo_rcoN_0", ilo.rcoN, 1);
    cnt = 8'h10;
    for (int k = 0; k < 40; k++) begin
      tick();
      cnt = cnt + 8'd1;
      chk($sformatf("casc_q%0d", k), {ihi.q, ilo.q}, cnt);
      chk($sformatf("casc_rco%0d", k), ilo.rcoN,
          (cnt[3:0] == 4'hF) ? 0 : 1);
    end

    // Async reset between edges, and clock ignored while held.
    @(negedge clk);
    drive0(2'b10, 1, 1, 8'hFF, 8'hFF, 0);
    tick();
    @(negedge clk);
    drive0(2'b11, 0, 0, 8'h00, 8'hFF, 0);
    tick();
    @(negedge clk);
    drive0(2'b10, 1, 1, 8'h33, 8'hFF, 0);
    tick();
    chk("pre_rst_q", i0.q, 8'h33);
    chk("pre_rst_w", i0.wrapped, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", i0.q, 8'h00);
    chk("async_rst_w", i0.wrapped, 0);
    drive0(2'b10, 1, 1, 8'hAA, 8'hFF, 0);
    tick();
    chk("rst_hold_q", i0.q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive0(2'b11, 0, 0, 8'h00, 8'hFF, 0);
    tick();
    chk("post_rst_q", i0.q, 8'h01);

    // Random stimulus against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    drive0(2'b00, 1, 1, 8'h00, 8'hFF, 0);
    drive1(2'b00, 1, 1, 8'h00, 8'hFF, 0);
    #2;
    rst_n = 1'b1;
    mq0 = 0; mq1 = 0; mw0 = 0; mw1 = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rs  = 2'($urandom_range(0, 3));
      rp  = ($urandom_range(0, 3) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      rc  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'($urandom);
      mod = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                        : 8'($urandom);
      drive0(rs, rp, rt, rd, mod, rc);
      drive1(rs, rp, rt, rd, mod, rc);
      top = top_of(mod);
      #1;
      chk("rnd_rco0", i0.rcoN, ref_rco(mq0, rs, rt, top));
      chk("rnd_rco1", i1.rcoN, ref_rco(mq1, rs, rt, top));
      nx = ref_next(0, mq0, mw0, rs, rp, rt, rd, top, rc);
      mq0 = nx[7:0]; mw0 = nx[8];
      nx = ref_next(1, mq1, mw1, rs, rp, rt, rd, top, rc);
      mq1 = nx[7:0]; mw1 = nx[8];
      tick();
      chk("rnd_q0", i0.q, mq0);
      chk("rnd_w0", i0.wrapped, mw0);
      chk("rnd_q1", i1.q, mq1);
      chk("rnd_w1", i1.wrapped, mw1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_cascade_counter.md
PARAM_CASCADE_COUNTER -- requirements
Module: param_cascade_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/data width (>=2).
REQ-002 SHALL have parameter ONESHOT, default 0, 1 = saturate at terminal instead of wrapping.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port asyncResetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s  input  2  mode select: 00 clear, 01 down, 10 load, 11 up.
REQ-006 SHALL have port enpN  input  1  count enable P, active-low.
REQ-007 SHALL have port entN  input  1  count enable T / cascade input, active-low.
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port modulo  input  WIDTH  programmable terminal value TOP (used only with macro).
REQ-010 SHALL have port clrWrap  input  1  synchronous clear of wrapped flag.
REQ-011 SHALL have port q  output  WIDTH  counter value.
REQ-012 SHALL have port rcoN  output  1  ripple carry out, active-low, combinational.
REQ-013 SHALL have port wrapped  output  1  sticky wrap/saturation flag.

Function
REQ-014 SHALL define en = ~enpN & ~entN; all state changes occur on rising clk only.
REQ-015 SHALL, s=10, load q<=d every edge regardless of enpN/entN.
REQ-016 SHALL, s=00 and en, clear q<=0; no change when !en.
REQ-017 SHALL, s=11 and en: q>=TOP -> q<=0 (ONESHOT=0) or hold q (ONESHOT=1); else q<=q+1.
REQ-018 SHALL, s=01 and en: q==0 -> q<=TOP (ONESHOT=0) or hold 0 (ONESHOT=1); else q<=q-1.
REQ-019 SHALL hold q on any edge with !en and s!=10.
REQ-020 SHALL drive rcoN=0 iff entN=0 and ((s=11 and q>=TOP) or (s=01 and q==0)); otherwise 1; independent of enpN.
REQ-021 SHALL set wrapped<=1 on every edge where REQ-017/018 terminal branch is taken (wrap or saturating hold).
REQ-022 SHALL clear wrapped<=0 on edge with clrWrap=1; simultaneous set and clear -> set wins.
REQ-023 SHALL keep arithmetic modulo 2^WIDTH, no carry bits beyond WIDTH.
REQ-024 SHALL allow cascading: rcoN of stage n to entN of stage n+1, shared clk/enpN/s, giving a synchronous N*WIDTH counter.
REQ-025 SHALL sample modulo combinationally each cycle; changes take effect the same cycle.

Reset
REQ-026 SHALL, asyncResetN=0, force q=0 and wrapped=0 immediately, independent of clk.
REQ-027 SHALL ignore clk edges while asyncResetN=0; first action on first rising clk after release.
REQ-028 SHALL abort in-progress counting/loading on reset mid-operation with no partial update.

Configuration
REQ-029 SHALL use macro PARAM_COUNTER_MODULO_EN to select terminal value TOP.
REQ-030 SHALL, macro defined, set TOP = modulo input.
REQ-031 SHALL, macro undefined, set TOP = all-ones (2^WIDTH-1), ignore modulo, and keep the modulo port.

Verification
REQ-032 SHALL verify WIDTH=8, no macro, s=11, en, q=8'hFE: edge -> q=FF, rcoN=0; edge -> q=00, wrapped=1, rcoN=1.
REQ-033 SHALL verify macro, modulo=9, s=11, from q=0: 10 edges -> q sequence 1..9,0; rcoN=0 only while q=9.
REQ-034 SHALL verify s=01, q=0, ONESHOT=1: 3 edges -> q stays 0, wrapped=1, rcoN=0 throughout.
REQ-035 SHALL verify s=10, enpN=entN=1, d=8'h5A: edge -> q=5A; then s=11, enpN=1: edge -> q=5A held.
REQ-036 SHALL verify two cascaded WIDTH=4 stages, up from 8'h0F: edge -> combined 8'h10; lower rcoN low only at q_low=F.
REQ-037 SHALL verify asyncResetN pulsed low between edges with q=8'h33, wrapped=1 -> q=0, wrapped=0 before next clk.
